i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (slave) responder for the other end of the bus driven by the team's I2C controller (START/WR/RD/STOP/RESTART command interface).
- Listens on scl/sda and matches a 7-bit address. It ACKs, then accepts a register pointer plus write data, or returns read data from an internal register file.
- Open-drain sda drive only: no clock stretching, scl is input-only.
- Used as the bus-side model/peripheral in the I2C subsystem and bench.

Parameters:
- TGT_ADDR, 7'h7D, 7-bit target address (address byte 8'hFA = write, 8'hFB = read).
- NREGS, 16, register file depth (power of 2).
- PW, 4, pointer width = log2(NREGS).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- scl_i  in  1  bus SCL level (asynchronous).
- sda_i  in  1  bus SDA level (asynchronous).
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- dbg_addr  in  PW  register file read-back address.
- dbg_data  out  8  regs[dbg_addr], combinational.
- wr_pulse  out  1  1-clk strobe when a data byte is written to regs.
- wr_addr  out  PW  register index written; valid with wr_pulse.
- busy  out  1  1 from START until STOP.
- start_det  out  1  1-clk strobe on START or repeated START.
- stop_det  out  1  1-clk strobe on STOP.

Behaviour:
- Reset values: sda_oe=0, busy=0, all strobes 0, wr_addr=0, ptr=0, all regs=8'h00, state IDLE. Reset is async, so sda releases immediately, including mid-transfer.
- Input sync: scl_i and sda_i each pass through 2 flops, then a third history flop for edge detect. Total detect latency is 3 clk.
- Bus timing requirement: each scl high/low phase ≥ 6 clk; sda changes ≥ 4 clk away from scl edges (the controller with dvsr=20 meets this).
- START: synced sda falls while synced scl=1. Valid in any state. Actions: start_det=1, busy=1, bit counter cleared, sda_oe=0, state→ADDR.
- STOP: synced sda rises while synced scl=1. Valid in any state. Actions: stop_det=1, busy=0, sda_oe=0, state→IDLE. A partial byte is discarded; ptr is retained.
- Data bits are sampled on synced scl rising edge, MSB first. sda_oe changes only on synced scl falling edge.
- States and transitions:
  - IDLE: ignore bus until START.
  - ADDR: shift 8 bits. After the 8th rise, compare bits[7:1] to TGT_ADDR and latch bit0 as rw. On match → ADDR_ACK. On mismatch → IDLE; sda is never driven.
  - ADDR_ACK: at next scl fall sda_oe=1; at the following fall release. rw=0 → PTR. rw=1 → load tx=regs[ptr] and drive bit7 on this same fall; state→RDATA.
  - PTR: shift 8 bits; ptr ← byte[PW-1:0] (upper bits ignored); ACK as above; → WDATA.
  - WDATA: shift 8 bits. After the 8th rise: regs[ptr] ← byte, wr_pulse=1, wr_addr=ptr, ptr ← ptr+1 (wraps NREGS-1→0). ACK as above; → WDATA.
  - RDATA: drive sda_oe=~tx[bit] on each scl fall. Release on the fall after bit0; → RACK.
  - RACK: sample controller ACK on the 9th rise. 0 (ACK): ptr ← ptr+1 (wrap); tx=regs[ptr+1]; drive its bit7 on the next fall; → RDATA. 1 (NACK): ptr ← ptr+1 (wrap); → IDLE (wait for STOP/START).
- The read pointer advances after every byte sent, whether ACKed or NACKed.
- Repeated START mid-byte or mid-ACK: sda is released in the same clk as detection; ptr is kept, so write-ptr then RESTART-read works.
- Simultaneous START or STOP with a scl edge is not possible, since scl must be high for either condition. START/STOP take priority over bit logic.
- busy stays 1 across a repeated START.

Test Plan:
- START, 8'hFA, 8'h03, 8'hA5, STOP → ACK (sda low) on the 9th clock of each byte; wr_pulse once with wr_addr=3; dbg_addr=3 gives 8'hA5; busy 1→0; start_det and stop_det each pulse once.
- START, 8'hA0, 8'h12, STOP → sda_oe never asserted; no wr_pulse; all regs remain 8'h00; stop_det pulses.
- After test 1, plus regs[4]=8'h5A: START, 8'hFA, 8'h03, RESTART, 8'hFB, read ACK, read NACK, STOP → read bytes 8'hA5 then 8'h5A; start_det pulses twice; ptr ends at 5.
- START, 8'hFA, 8'h0F, 8'h11, 8'h22, STOP → regs[15]=8'h11, regs[0]=8'h22 (pointer wrap); wr_addr sequence 15, 0.
- Assert rst while sda_oe=1 during an address ACK → sda_oe=0 in the same cycle (async); after release, all regs read 8'h00; state IDLE.
- START, 8'hFA, 8'h02, 4 data bits, STOP → partial byte discarded; no wr_pulse; regs[2] unchanged; next START, 8'hFB read returns regs[2].

Source files
------------

// File: rtl/i2c_target.sv
// ==== i2c_target : I2C target, 7-bit address match, pointer + register file access ====
// Rev 1.0
`default_nettype none

module i2c_target #(
   parameter logic [6:0] TGT_ADDR = 7'h7D,
   parameter int         NREGS    = 16,
   parameter int         PW       = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   input  logic [PW-1:0] dbg_addr,
   output logic [7:0]    dbg_data,
   output logic          wr_pulse,
   output logic [PW-1:0] wr_addr,
   output logic          busy,
   output logic          start_det,
   output logic          stop_det
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_DATA_ACK, S_WDATA, S_RDATA, S_RACK
   } state_t;

   logic          r_scl_s1, r_scl_s2, r_scl_d;
   logic          r_sda_s1, r_sda_s2, r_sda_d;
   state_t        r_state, w_state;
   logic [2:0]    r_cnt, w_cnt;
   logic [6:0]    r_shift, w_shift;
   logic          r_rw, w_rw;
   logic [PW-1:0] r_ptr, w_ptr;
   logic [7:0]    r_tx, w_tx;
   logic          r_ack_on, w_ack_on;
   logic          r_sda_oe, w_sda_oe;
   logic          r_busy, w_busy;
   logic          r_start_det, w_start_det;
   logic          r_stop_det, w_stop_det;
   logic          r_wr_pulse, w_wr_pulse;
   logic [PW-1:0] r_wr_addr, w_wr_addr;
   logic [7:0]    r_regs [NREGS];

   logic          w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0]    w_byte;
   logic [PW-1:0] w_ptr_inc;

   assign w_scl_rise = r_scl_s2 & ~r_scl_d;
   assign w_scl_fall = ~r_scl_s2 & r_scl_d;
   assign w_start    = r_scl_s2 & r_sda_d & ~r_sda_s2;
   assign w_stop     = r_scl_s2 & ~r_sda_d & r_sda_s2;
   assign w_byte     = {r_shift, r_sda_s2};
   assign w_ptr_inc  = r_ptr + 1'b1;

   // Synchronisers reset to the idle-bus level so no false START/STOP follows reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
         r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
      end else begin
         r_scl_s1 <= scl_i;    r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
         r_sda_s1 <= sda_i;    r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_rw        <= 1'b0;
         r_ptr       <= '0;
         r_tx        <= '0;
         r_ack_on    <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_start_det <= 1'b0;
         r_stop_det  <= 1'b0;
         r_wr_pulse  <= 1'b0;
         r_wr_addr   <= '0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_shift     <= w_shift;
         r_rw        <= w_rw;
         r_ptr       <= w_ptr;
         r_tx        <= w_tx;
         r_ack_on    <= w_ack_on;
         r_sda_oe    <= w_sda_oe;
         r_busy      <= w_busy;
         r_start_det <= w_start_det;
         r_stop_det  <= w_stop_det;
         r_wr_pulse  <= w_wr_pulse;
         r_wr_addr   <= w_wr_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
      end else if (w_wr_pulse) begin
         r_regs[r_ptr] <= w_byte;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_shift     = r_shift;
      w_rw        = r_rw;
      w_ptr       = r_ptr;
      w_tx        = r_tx;
      w_ack_on    = r_ack_on;
      w_sda_oe    = r_sda_oe;
      w_busy      = r_busy;
      w_start_det = 1'b0;
      w_stop_det  = 1'b0;
      w_wr_pulse  = 1'b0;
      w_wr_addr   = r_wr_addr;

      // Bus conditions override whatever bit/ACK phase was in progress
      if (w_start) begin
         w_start_det = 1'b1;
         w_busy      = 1'b1;
         w_cnt       = '0;
         w_sda_oe    = 1'b0;
         w_ack_on    = 1'b0;
         w_state     = S_ADDR;
      end else if (w_stop) begin
         w_stop_det  = 1'b1;
         w_busy      = 1'b0;
         w_sda_oe    = 1'b0;
         w_ack_on    = 1'b0;
         w_state     = S_IDLE;
      end else begin
         case (r_state)
            S_ADDR, S_PTR, S_WDATA: begin
               if (w_scl_rise) begin
                  w_shift = w_byte[6:0];
                  w_cnt   = r_cnt + 3'd1;
                  if (r_cnt == 3'd7) begin
                     w_ack_on = 1'b0;
                     if (r_state == S_ADDR) begin
                        w_rw    = w_byte[0];
                        w_state = (w_byte[7:1] == TGT_ADDR) ? S_ADDR_ACK : S_IDLE;
                     end else if (r_state == S_PTR) begin
                        w_ptr   = w_byte[PW-1:0];
                        w_state = S_DATA_ACK;
                     end else begin
                        w_wr_pulse = 1'b1;
                        w_wr_addr  = r_ptr;
                        w_ptr      = w_ptr_inc;
                        w_state    = S_DATA_ACK;
                     end
                  end
               end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
               if (w_scl_fall) begin
                  w_cnt = '0;
                  if (!r_ack_on) begin
                     w_sda_oe = 1'b1;
                     w_ack_on = 1'b1;
                  end else begin
                     w_ack_on = 1'b0;
                     // A read hands the bus straight to the first data bit on this fall
                     if (r_state == S_ADDR_ACK && r_rw) begin
                        w_tx     = r_regs[r_ptr];
                        w_sda_oe = ~r_regs[r_ptr][7];
                        w_state  = S_RDATA;
                     end else begin
                        w_sda_oe = 1'b0;
                        w_state  = (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                     end
                  end
               end
            end
            S_RDATA: begin
               if (w_scl_fall) begin
                  if (r_cnt == 3'd7) begin
                     w_sda_oe = 1'b0;
                     w_cnt    = '0;
                     w_ack_on = 1'b0;
                     w_state  = S_RACK;
                  end else begin
                     w_cnt    = r_cnt + 3'd1;
                     w_tx     = {r_tx[6:0], 1'b0};
                     w_sda_oe = ~r_tx[6];
                  end
               end
            end
            S_RACK: begin
               if (w_scl_rise && !r_ack_on) begin
                  w_ptr = w_ptr_inc;
                  if (!r_sda_s2) begin
                     w_tx     = r_regs[w_ptr_inc];
                     w_ack_on = 1'b1;
                  end else begin
                     w_state  = S_IDLE;
                  end
               end else if (w_scl_fall && r_ack_on) begin
                  w_sda_oe = ~r_tx[7];
                  w_ack_on = 1'b0;
                  w_cnt    = '0;
                  w_state  = S_RDATA;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe    = r_sda_oe;
   assign busy      = r_busy;
   assign start_det = r_start_det;
   assign stop_det  = r_stop_det;
   assign wr_pulse  = r_wr_pulse;
   assign wr_addr   = r_wr_addr;
   assign dbg_data  = r_regs[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ==== tb_i2c_target : directed bus-level bench for i2c_target ====
// Rev 1.0
`default_nettype none

module tb_i2c_target;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_i;
   logic       sda_oe;
   logic [3:0] dbg_addr = 4'd0;
   logic [7:0] dbg_data;
   logic       wr_pulse;
   logic [3:0] wr_addr;
   logic       busy;
   logic       start_det;
   logic       stop_det;

   int total = 0;
   int bad   = 0;
   int start_cnt = 0, stop_cnt = 0, oe_cnt = 0;
   int wr_log[$];

   // Open-drain wired-AND of controller and target
   assign sda_i = sda_m & ~sda_oe;

   i2c_target #(.TGT_ADDR(7'h7D), .NREGS(16), .PW(4)) dut (
      .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_i), .sda_oe(sda_oe),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_pulse(wr_pulse),
      .wr_addr(wr_addr), .busy(busy), .start_det(start_det), .stop_det(stop_det)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (start_det) start_cnt++;
      if (stop_det)  stop_cnt++;
      if (sda_oe)    oe_cnt++;
      if (wr_pulse)  wr_log.push_back(int'(wr_addr));
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      tick(4); sda_m = b; tick(4); scl = 1'b1; tick(8); scl = 1'b0;
   endtask

   task automatic bus_start();
      tick(8); sda_m = 1'b0; tick(8); scl = 1'b0;
   endtask

   task automatic bus_restart();
      tick(4); sda_m = 1'b1; tick(4); scl = 1'b1; tick(8); sda_m = 1'b0; tick(8); scl = 1'b0;
   endtask

   task automatic bus_stop();
      tick(4); sda_m = 1'b0; tick(4); scl = 1'b1; tick(8); sda_m = 1'b1; tick(8);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      tick(4); sda_m = 1'b1; tick(4); scl = 1'b1; tick(4);
      ack = ~sda_i;
      tick(4); scl = 1'b0;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick(4); sda_m = 1'b1; tick(4); scl = 1'b1; tick(4);
         d = {d[6:0], sda_i};
         tick(4); scl = 1'b0;
      end
      send_bit(nack);
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(3); rst = 1'b0; tick(4);
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if ({wr_pulse, start_det, stop_det} !== 3'b000) begin
         bad++; $display("FAIL reset_strobes: got %b want 000", {wr_pulse, start_det, stop_det}); end
      total++; if (wr_addr !== 4'd0) begin bad++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i); #1;
         total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL reset_reg%0d: got %h want 00", i, dbg_data); end
      end
   endtask

   task automatic test_nomatch();
      logic ack;
      int oe0 = oe_cnt, wr0 = wr_log.size(), sp0 = stop_cnt;
      bus_start();
      write_byte(8'hA0, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL nomatch_addr_ack: got %b want 0", ack); end
      write_byte(8'h12, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL nomatch_data_ack: got %b want 0", ack); end
      bus_stop(); tick(6);
      total++; if (oe_cnt != oe0) begin bad++; $display("FAIL nomatch_oe: got %0d drive cycles want 0", oe_cnt - oe0); end
      total++; if (wr_log.size() != wr0) begin bad++; $display("FAIL nomatch_wr: got %0d writes want 0", wr_log.size() - wr0); end
      total++; if (stop_cnt - sp0 != 1) begin bad++; $display("FAIL nomatch_stop: got %0d want 1", stop_cnt - sp0); end
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i); #1;
         total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL nomatch_reg%0d: got %h want 00", i, dbg_data); end
      end
   endtask

   task automatic test_write();
      logic ack;
      int wr0 = wr_log.size(), st0 = start_cnt, sp0 = stop_cnt;
      bus_start();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy_on: got %b want 1", busy); end
      write_byte(8'hFA, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL write_addr_ack: got %b want 1", ack); end
      write_byte(8'h03, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL write_ptr_ack: got %b want 1", ack); end
      write_byte(8'hA5, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL write_data_ack: got %b want 1", ack); end
      bus_stop(); tick(6);
      total++; if (wr_log.size() - wr0 != 1) begin bad++; $display("FAIL write_count: got %0d want 1", wr_log.size() - wr0); end
      else begin
         total++; if (wr_log[wr0] != 3) begin bad++; $display("FAIL write_wr_addr: got %0d want 3", wr_log[wr0]); end
      end
      dbg_addr = 4'd3; #1;
      total++; if (dbg_data !== 8'hA5) begin bad++; $display("FAIL write_reg3: got %h want a5", dbg_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_off: got %b want 0", busy); end
      total++; if (start_cnt - st0 != 1) begin bad++; $display("FAIL write_start: got %0d want 1", start_cnt - st0); end
      total++; if (stop_cnt - sp0 != 1) begin bad++; $display("FAIL write_stop: got %0d want 1", stop_cnt - sp0); end
   endtask

   task automatic test_restart_read();
      logic ack;
      logic [7:0] d;
      int st0;
      // regs[4]=5A, regs[5]=C3
      bus_start(); write_byte(8'hFA, ack); write_byte(8'h04, ack);
      write_byte(8'h5A, ack); write_byte(8'hC3, ack); bus_stop(); tick(6);
      st0 = start_cnt;
      bus_start(); write_byte(8'hFA, ack); write_byte(8'h03, ack);
      bus_restart();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy_restart: got %b want 1", busy); end
      write_byte(8'hFB, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL rd_addr_ack: got %b want 1", ack); end
      read_byte(d, 1'b0);
      total++; if (d !== 8'hA5) begin bad++; $display("FAIL rd_byte0: got %h want a5", d); end
      read_byte(d, 1'b1);
      total++; if (d !== 8'h5A) begin bad++; $display("FAIL rd_byte1: got %h want 5a", d); end
      bus_stop(); tick(6);
      total++; if (start_cnt - st0 != 2) begin bad++; $display("FAIL rd_starts: got %0d want 2", start_cnt - st0); end
      // Pointer must now be 5
      bus_start(); write_byte(8'hFB, ack); read_byte(d, 1'b1); bus_stop(); tick(6);
      total++; if (d !== 8'hC3) begin bad++; $display("FAIL rd_ptr5: got %h want c3", d); end
   endtask

   task automatic test_wrap();
      logic ack;
      int wr0 = wr_log.size();
      bus_start(); write_byte(8'hFA, ack); write_byte(8'h0F, ack);
      write_byte(8'h11, ack); write_byte(8'h22, ack); bus_stop(); tick(6);
      total++; if (wr_log.size() - wr0 != 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", wr_log.size() - wr0); end
      else begin
         total++; if (wr_log[wr0] != 15 || wr_log[wr0+1] != 0) begin
            bad++; $display("FAIL wrap_wr_addr: got %0d,%0d want 15,0", wr_log[wr0], wr_log[wr0+1]); end
      end
      dbg_addr = 4'd15; #1;
      total++; if (dbg_data !== 8'h11) begin bad++; $display("FAIL wrap_reg15: got %h want 11", dbg_data); end
      dbg_addr = 4'd0; #1;
      total++; if (dbg_data !== 8'h22) begin bad++; $display("FAIL wrap_reg0: got %h want 22", dbg_data); end
   endtask

   task automatic test_partial();
      logic ack;
      logic [7:0] d;
      int wr0;
      bus_start(); write_byte(8'hFA, ack); write_byte(8'h02, ack);
      write_byte(8'h77, ack); bus_stop(); tick(6);
      wr0 = wr_log.size();
      bus_start(); write_byte(8'hFA, ack); write_byte(8'h02, ack);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      bus_stop(); tick(6);
      total++; if (wr_log.size() != wr0) begin bad++; $display("FAIL partial_wr: got %0d writes want 0", wr_log.size() - wr0); end
      dbg_addr = 4'd2; #1;
      total++; if (dbg_data !== 8'h77) begin bad++; $display("FAIL partial_reg2: got %h want 77", dbg_data); end
      bus_start(); write_byte(8'hFB, ack); read_byte(d, 1'b1); bus_stop(); tick(6);
      total++; if (d !== 8'h77) begin bad++; $display("FAIL partial_read: got %h want 77", d); end
   endtask

   task automatic test_async_reset();
      logic ack;
      logic [7:0] a = 8'hFA;
      int oe0;
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(a[i]);
      tick(4);
      total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL arst_ack_drive: got %b want 1", sda_oe); end
      #1 rst = 1'b1;
      #1;
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL arst_release: got %b want 0", sda_oe); end
      sda_m = 1'b1; scl = 1'b1;
      tick(3); rst = 1'b0; tick(4);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i); #1;
         total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL arst_reg%0d: got %h want 00", i, dbg_data); end
      end
      // Without a START the target must stay silent
      scl = 1'b0; tick(8);
      oe0 = oe_cnt;
      write_byte(8'hFA, ack);
      total++; if (ack !== 1'b0 || oe_cnt != oe0) begin
         bad++; $display("FAIL arst_idle: got ack=%b drive=%0d want ack=0 drive=0", ack, oe_cnt - oe0); end
   endtask

   initial begin
      test_reset();
      test_nomatch();
      test_write();
      test_restart_read();
      test_wrap();
      test_partial();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
